// File: rtl/mux_arb_pkg.sv
// Shared constants and types for the round-robin output-mux arbiter.
// Optional packet lock is enabled by defining MUX_ARB_PKT_LOCK_EN.
package mux_arb_pkg;

    localparam int N_REQ_DEF = 4;
    localparam int W_DEF     = 8;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef logic [$clog2(N_REQ_DEF)-1:0] src_t;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } ostate_t;

endpackage

// File: rtl/mux_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit of req after last,
// wrapping modulo N. Reusable by any shared-resource controller.
module rr_pick
    import mux_arb_pkg::*;
#(
    parameter int N  = N_REQ_DEF,
    parameter int IW = idx_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gidx,
    output logic          any
);

    always_comb begin
        int idx;
        gnt  = '0;
        gidx = '0;
        any  = 1'b0;
        idx  = 0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(last) + k) % N;
            if (!any && req[idx]) begin
                any      = 1'b1;
                gnt[idx] = 1'b1;
                gidx     = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter sharing one registered W-bit output between N_REQ
// valid/ready requesters. Define MUX_ARB_PKT_LOCK_EN for packet lock.
module mux_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int W     = W_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [N_REQ*W-1:0]       req_data,
`ifdef MUX_ARB_PKT_LOCK_EN
    input  logic [N_REQ-1:0]         req_last,
`endif
    output logic [N_REQ-1:0]         req_ready,
    output logic                     out_valid,
    output logic [W-1:0]             out_data,
    output logic [$clog2(N_REQ)-1:0] out_src,
    input  logic                     out_ready
);

    localparam int IW = idx_w(N_REQ);

    ostate_t         state;
    logic [IW-1:0]   last;
    logic [N_REQ-1:0] pick_gnt;
    logic [IW-1:0]   pick_gidx;
    logic            pick_any;
    logic [N_REQ-1:0] gnt;
    logic [IW-1:0]   gidx;
    logic            can_load;
    logic            accept;
    logic [W-1:0]    sel_data;

    rr_pick #(
        .N  (N_REQ),
        .IW (IW)
    ) u_pick (
        .req  (req_valid),
        .last (last),
        .gnt  (pick_gnt),
        .gidx (pick_gidx),
        .any  (pick_any)
    );

`ifdef MUX_ARB_PKT_LOCK_EN
    logic lock;

    // While locked the owner keeps the mux; others stall even if valid.
    always_comb begin
        gnt  = pick_gnt;
        gidx = pick_gidx;
        if (lock) begin
            gnt       = '0;
            gnt[last] = req_valid[last];
            gidx      = last;
        end
    end
`else
    assign gnt  = pick_gnt;
    assign gidx = pick_gidx;
`endif

    assign out_valid = (state == FULL);
    assign can_load  = ~out_valid | out_ready;
    assign req_ready = gnt & {N_REQ{can_load & rst_n}};
    assign accept    = |(req_valid & req_ready);
    assign sel_data  = req_data[int'(gidx)*W +: W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= EMPTY;
            out_data <= '0;
            out_src  <= '0;
            last     <= IW'(N_REQ - 1);
`ifdef MUX_ARB_PKT_LOCK_EN
            lock     <= 1'b0;
`endif
        end else if (accept) begin
            state    <= FULL;
            out_data <= sel_data;
            out_src  <= gidx;
            last     <= gidx;
`ifdef MUX_ARB_PKT_LOCK_EN
            lock     <= ~req_last[gidx];
`endif
        end else if (out_ready) begin
            state <= EMPTY;
        end
    end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed self-checking bench for mux_rr_arbiter (N_REQ=4, W=8).
// Packet-lock steps run only when MUX_ARB_PKT_LOCK_EN is defined.
module tb_mux_rr_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ready;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic [1:0]     out_src;
    logic           out_ready;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mux_rr_arbiter #(.N_REQ(N), .W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
`ifdef MUX_ARB_PKT_LOCK_EN
        .req_last  (req_last),
`endif
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_ready (out_ready)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [1:0] src);
        chk({tag, ".valid"}, 32'(out_valid), 32'd1);
        chk({tag, ".src"}, 32'(out_src), 32'(src));
        chk({tag, ".data"}, 32'(out_data), 32'h A0 + 32'(src));
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 4'b1111;
        req_data  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        req_last  = 4'b1111;
        out_ready = 1'b1;
        repeat (2) step();
        chk("rst.valid", 32'(out_valid), 32'd0);
        chk("rst.data", 32'(out_data), 32'd0);
        chk("rst.src", 32'(out_src), 32'd0);
        chk("rst.ready", 32'(req_ready), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("rr.ready0", 32'(req_ready), 32'b0001);

        for (int i = 0; i < 8; i++) begin
            step();
            chk_out("rr", 2'(i % 4));
        end

        req_valid = 4'b0110;
        step();
        chk_out("bp.first", 2'd1);
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp.ready", 32'(req_ready), 32'd0);
            step();
            chk_out("bp.hold", 2'd1);
        end
        out_ready = 1'b1;
        step();
        chk_out("bp.next", 2'd2);

        req_valid = 4'b1000;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_out("sparse", 2'd3);
        end
        req_valid = 4'b1001;
        step();
        chk_out("wrap.a", 2'd0);
        step();
        chk_out("wrap.b", 2'd3);

        req_valid = 4'b0010;
        step();
        chk_out("ph.grant", 2'd1);
        out_ready = 1'b0;
        req_valid = 4'b0100;
        step();
        chk("ph.ready", 32'(req_ready), 32'd0);
        step();
        req_valid = 4'b0000;
        step();
        req_valid = 4'b1001;
        out_ready = 1'b1;
        step();
        chk_out("ph.after", 2'd3);
        step();
        chk_out("ph.after2", 2'd0);

        req_valid = 4'b0000;
        step();
        chk("drain.valid", 32'(out_valid), 32'd0);
        req_valid = 4'b0110;
        #1;
        chk("comb.ready", 32'(req_ready), 32'b0010);
        step();
        chk_out("pre.rst", 2'd1);

        #2;
        rst_n = 1'b0;
        #1;
        chk("arst.valid", 32'(out_valid), 32'd0);
        chk("arst.data", 32'(out_data), 32'd0);
        chk("arst.src", 32'(out_src), 32'd0);
        chk("arst.ready", 32'(req_ready), 32'd0);
        step();
        rst_n = 1'b1;
        req_valid = 4'b1111;
        step();
        chk_out("arst.first", 2'd0);

`ifdef MUX_ARB_PKT_LOCK_EN
        req_valid = 4'b0001;
        req_last  = 4'b1111;
        step();
        chk_out("lk.seed", 2'd0);
        req_valid = 4'b0111;
        req_last  = 4'b1101;
        step();
        chk_out("lk.b0", 2'd1);
        step();
        chk_out("lk.b1", 2'd1);
        req_last = 4'b1111;
        step();
        chk_out("lk.b2", 2'd1);
        step();
        chk_out("lk.next", 2'd2);
        step();
        chk_out("lk.wrap", 2'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mux_rr_arbiter.md
Name: mux_rr_arbiter

Overview:
Shares one W-bit output mux between N_REQ requesters, each with a valid/ready handshake.
- Round-robin arbitration drives the mux select.
- The selected word is captured in a single output register with valid/ready toward the consumer.
- Sits between several producer blocks and one downstream consumer; it sequences the shared selection path instead of leaving a free-running `sel`.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- W, 8, data width per requester.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req_valid  input  N_REQ  per-requester valid.
- req_data  input  N_REQ*W  packed data; requester i occupies bits [i*W +: W].
- req_ready  output  N_REQ  per-requester ready; at most one bit high per cycle.
- out_valid  output  1  output register holds a word.
- out_data  output  W  registered output word.
- out_src  output  $clog2(N_REQ)  index of the requester that supplied out_data.
- out_ready  input  1  consumer accepts the word when out_valid & out_ready.

Behaviour:
- Reset (async assert, sync release):
  - out_valid=0, out_data=0, out_src=0.
  - Round-robin pointer last=N_REQ-1, so requester 0 has highest priority first.
  - req_ready=0 while rst_n=0.
- Output register states:
  - EMPTY (out_valid=0). EMPTY -> FULL on accept.
  - FULL (out_valid=1). FULL -> EMPTY on out_ready with no new accept. FULL -> FULL on out_ready with a same-cycle accept (back-to-back, full throughput).
- can_load = ~out_valid | out_ready.
- Pick (combinational):
  - Search req_valid for the first set bit starting at index last+1, wrapping modulo N_REQ.
  - Produces a one-hot gnt and index gidx.
  - No valid requester -> gnt=0.
- req_ready = gnt & {N_REQ{can_load}}.
  - req_ready depends on req_valid, as is usual for arbiters.
  - Requesters must not make req_valid depend on req_ready.
- Accept = |(req_valid & req_ready). On accept:
  - out_data <= req_data[gidx].
  - out_src <= gidx.
  - out_valid <= 1.
  - last <= gidx.
- last changes only on accept. A requester that drops valid without a transfer does not move the pointer.
- Latency: requester transfer to out_valid is 1 cycle. Sustained throughput is 1 word/cycle when out_ready=1.
- Holding: while out_valid=1 & out_ready=0:
  - All req_ready=0.
  - out_data and out_src stable.
- Fairness: with all requesters continuously valid, grants cycle 0,1,...,N_REQ-1,0,...
- Only requester i valid: it wins every cycle (pointer wrap does not block it).
- Reset mid-transfer: the output word is discarded, out_valid drops immediately (async), and the pointer returns to N_REQ-1.
- The X check on req_valid is not required; the design must be X-free after reset.

Optional Feature:
Macro MUX_ARB_PKT_LOCK_EN enables packet lock.
- With the macro defined:
  - Adds input req_last, N_REQ bits.
  - After an accept with req_last[gidx]=0, the grant is locked to gidx.
  - The pick logic is bypassed: gnt=onehot(gidx) if req_valid[gidx], else 0. Other requesters stall even if valid.
  - The lock clears on an accept with req_last[gidx]=1, after which round-robin resumes from last=gidx.
  - Reset clears the lock.
- Without the macro: the req_last port does not exist and every beat is arbitrated independently.

Decomposition:
- Package mux_arb_pkg holds:
  - default N_REQ and W constants.
  - function clog2-safe index width.
  - typedef for the src index.
- One sub-module, rr_pick: combinational round-robin picker.
  - Inputs: req vector and last pointer.
  - Outputs: one-hot gnt, index gidx, any.
  - Instantiated once in mux_rr_arbiter.
  - Reusable by other shared-resource controllers.

Test Plan:
- Reset: assert rst_n=0 mid-run with out_valid=1 -> out_valid=0, out_data=0, out_src=0 within the same cycle; after release, req_valid=4'b1111 -> first out_src=0.
- Round robin: req_valid=4'b1111, data i=8'hA0+i, out_ready=1 for 8 cycles -> out_src sequence 0,1,2,3,0,1,2,3, out_data A0..A3 repeated, one word per cycle.
- Backpressure: out_ready=0 with req_valid=4'b0110 -> after one accept (src 1, data A1), req_ready=0 and out_data stable for 5 cycles; raise out_ready -> next word src 2 on the following edge.
- Sparse and wrap: req_valid=4'b1000 only for 3 beats -> out_src=3 each beat; then 4'b1001 -> src 0 then 3.
- Pointer hold: after grant to 1, requester 2 raises and drops valid while out_ready=0 -> on release, the next grant follows round-robin from last=1 (2 if valid, else 3, 0).
- MUX_ARB_PKT_LOCK_EN: requester 1 sends 3 beats with last=0,0,1 while requesters 0 and 2 are valid -> out_src=1,1,1, then 2, then 0.
